// File: rtl/eeprom_pkg.sv
// eeprom_pkg: READ opcode and controller state encoding shared by the EEPROM stream reader.
package eeprom_pkg;
  localparam logic [7:0] READ_OP = 8'h03;
  typedef enum logic [2:0] {IDLE, CMD, ADDR, READ, HOLD, DONE} state_e;
endpackage

// File: rtl/spi_byte_shifter.sv
// spi_byte_shifter: mode-0 SPI byte engine, MSB-first out, SCLK of CLK_DIV-cycle half-periods, one-cycle done after the 8th high phase.
module spi_byte_shifter #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       stop,
  input  logic       go,
  input  logic [7:0] din,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic       done,
  output logic [7:0] dout
);
  localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic          active_q, hi_q, done_q, half_end;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    tx_q, rx_q;
  assign half_end = cnt_q == CW'(CLK_DIV - 1);
  assign sclk = hi_q;
  assign mosi = active_q & tx_q[7];
  assign done = done_q;
  assign dout = rx_q;
  // MISO is captured on the rising edge, MOSI advances only on the falling edge
  always_ff @(posedge clk) begin
    if (reset || stop) begin
      active_q <= 1'b0;
      hi_q     <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      bit_q    <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
    end else begin
      done_q <= 1'b0;
      if (!active_q) begin
        if (go) begin
          active_q <= 1'b1;
          tx_q     <= din;
          cnt_q    <= '0;
          bit_q    <= '0;
        end
      end else if (!half_end) cnt_q <= cnt_q + 1'b1;
      else begin
        cnt_q <= '0;
        hi_q  <= !hi_q;
        if (!hi_q) rx_q <= {rx_q[6:0], miso};
        else if (bit_q == 3'd7) begin
          active_q <= 1'b0;
          done_q   <= 1'b1;
        end else begin
          bit_q <= bit_q + 3'd1;
          tx_q  <= {tx_q[6:0], 1'b0};
        end
      end
    end
  end
endmodule

// File: rtl/eeprom_stream_reader.sv
// eeprom_stream_reader: SPI EEPROM READ of BYTE_COUNT bytes into a valid/ready stream.
// Define EEPROM_STREAM_ABORT_EN to add the abort input.
module eeprom_stream_reader import eeprom_pkg::*; #(
  parameter int BYTE_COUNT = 100,
  parameter int CLK_DIV    = 2
) (
  input  logic       clk,
  input  logic       reset,
`ifdef EEPROM_STREAM_ABORT_EN
  input  logic       abort,
`endif
  input  logic       start,
  input  logic [7:0] start_addr,
  output logic       busy,
  output logic       done,
  output logic       eeprom_cs,
  output logic       eeprom_clk,
  output logic       eeprom_in,
  input  logic       eeprom_out,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  input  logic       byte_ready
);
  state_e     state_q, state_d;
  logic [7:0] addr_q, addr_d, data_q, data_d, sh_din, sh_dout;
  logic [8:0] cnt_q, cnt_d;
  logic       kill, more, sh_go, sh_done;
`ifdef EEPROM_STREAM_ABORT_EN
  assign kill = abort && state_q != IDLE;
`else
  assign kill = 1'b0;
`endif
  assign more   = (cnt_q + 9'd1) < 9'(BYTE_COUNT);
  // each shift is launched on the edge that enters its state, so no idle gap follows acceptance
  assign sh_go  = (state_q == IDLE && start) || ((state_q == CMD || state_q == ADDR) && sh_done)
                || (state_q == HOLD && byte_ready && more);
  assign sh_din = state_q == IDLE ? READ_OP : state_q == CMD ? addr_q : 8'h00;
  spi_byte_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clk(clk), .reset(reset), .stop(kill), .go(sh_go), .din(sh_din), .miso(eeprom_out),
    .sclk(eeprom_clk), .mosi(eeprom_in), .done(sh_done), .dout(sh_dout)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = CMD;
        addr_d  = start_addr;
        cnt_d   = '0;
      end
      CMD:  if (sh_done) state_d = ADDR;
      ADDR: if (sh_done) state_d = READ;
      READ: if (sh_done) begin
        state_d = HOLD;
        data_d  = sh_dout;
      end
      HOLD: if (byte_ready) begin
        state_d = more ? READ : DONE;
        cnt_d   = cnt_q + 9'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (kill) state_d = IDLE;
  end
  always_comb begin
    eeprom_cs  = state_q == IDLE || state_q == DONE;
    busy       = state_q != IDLE;
    done       = state_q == DONE;
    byte_valid = state_q == HOLD;
    byte_data  = data_q;
  end
endmodule

// File: tb/tb_eeprom_stream_reader.sv
// tb_eeprom_stream_reader: EEPROM model plus transaction-level scoreboard for two reader configurations (4 bytes/div 2, 256 bytes/div 1).
module tb_eeprom_stream_reader;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic [1:0] reset, start, byte_ready, busy, done, cs, sclk, mosi, miso, bvalid;
  logic [7:0] start_addr [2];
  logic [7:0] bdata [2];
`ifdef EEPROM_STREAM_ABORT_EN
  logic [1:0] abort;
`endif
  eeprom_stream_reader #(.BYTE_COUNT(4), .CLK_DIV(2)) u0 (
    .clk(clk), .reset(reset[0]),
`ifdef EEPROM_STREAM_ABORT_EN
    .abort(abort[0]),
`endif
    .start(start[0]), .start_addr(start_addr[0]), .busy(busy[0]), .done(done[0]),
    .eeprom_cs(cs[0]), .eeprom_clk(sclk[0]), .eeprom_in(mosi[0]), .eeprom_out(miso[0]),
    .byte_data(bdata[0]), .byte_valid(bvalid[0]), .byte_ready(byte_ready[0])
  );
  eeprom_stream_reader #(.BYTE_COUNT(256), .CLK_DIV(1)) u1 (
    .clk(clk), .reset(reset[1]),
`ifdef EEPROM_STREAM_ABORT_EN
    .abort(abort[1]),
`endif
    .start(start[1]), .start_addr(start_addr[1]), .busy(busy[1]), .done(done[1]),
    .eeprom_cs(cs[1]), .eeprom_clk(sclk[1]), .eeprom_in(mosi[1]), .eeprom_out(miso[1]),
    .byte_data(bdata[1]), .byte_valid(bvalid[1]), .byte_ready(byte_ready[1])
  );
  int vecs = 0, errs = 0;
  logic [7:0] mem [256];
  int bc [2], cd [2], xfer [2], dones [2], rise [2], since_cs [2], stab [2];
  bit mb [2], first_rise [2];
  logic [7:0] ea [2], pdat [2];
  logic [15:0] cmd [2];
  logic pv [2], psclk [2], pmosi [2], pdone [2];
  logic [7:0] got0 [$];
  logic [7:0] lit [4] = '{8'hA5, 8'h3C, 8'h00, 8'hFF};

  task automatic chk(input int g, input string nm, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL u%0d %s: got %0h expected %0h at %0t", g, nm, act, exp, $time);
    end
  endtask

  // SPI EEPROM: first 16 rising edges carry opcode+address, data bits shift out after each falling edge
  task automatic eeprom(input int g);
    int d;
    logic [7:0] a;
    if (cs[g]) begin
      rise[g] = 0;
      miso[g] = 1'b0;
    end else begin
      if (sclk[g] && !psclk[g]) begin
        if (rise[g] < 16) cmd[g] = {cmd[g][14:0], mosi[g]};
        rise[g]++;
      end
      if (!sclk[g] && psclk[g] && rise[g] >= 16) begin
        d = rise[g] - 16;
        a = cmd[g][7:0] + 8'(d / 8);
        miso[g] = mem[a][3'(7 - d % 8)];
      end
    end
  endtask

  task automatic compare(input int g);
    bit killed;
    killed = 1'b0;
    if (reset[g]) begin
      chk(g, "rst_cs", cs[g], 1);
      chk(g, "rst_sclk", sclk[g], 0);
      chk(g, "rst_mosi", mosi[g], 0);
      chk(g, "rst_valid", bvalid[g], 0);
      chk(g, "rst_busy", busy[g], 0);
      chk(g, "rst_done", done[g], 0);
      chk(g, "rst_data", bdata[g], 0);
      mb[g] = 1'b0;
      xfer[g] = 0;
      pv[g] = 1'b0;
    end else begin
`ifdef EEPROM_STREAM_ABORT_EN
      killed = abort[g] && mb[g] && !pdone[g];
`endif
      if (pdone[g] || killed) mb[g] = 1'b0;
      else if (start[g] && !mb[g]) begin
        mb[g] = 1'b1;
        ea[g] = start_addr[g];
        xfer[g] = 0;
      end
      chk(g, "busy", busy[g], mb[g]);
      if (pv[g] && !killed) begin
        if (byte_ready[g]) begin
          chk(g, "byte", pdat[g], mem[8'(ea[g] + 8'(xfer[g]))]);
          if (g == 0) got0.push_back(pdat[g]);
          xfer[g]++;
        end else begin
          chk(g, "hold_valid", bvalid[g], 1);
          chk(g, "hold_data", bdata[g], pdat[g]);
        end
      end
      if (bvalid[g]) begin
        chk(g, "stall_sclk", sclk[g], 0);
        chk(g, "stall_cs", cs[g], 0);
      end
      if (!mb[g]) begin
        chk(g, "idle_cs", cs[g], 1);
        chk(g, "idle_sclk", sclk[g], 0);
      end
      if (done[g]) begin
        chk(g, "done_single", pdone[g], 0);
        chk(g, "done_count", xfer[g], bc[g]);
        chk(g, "cmd", cmd[g], {8'h03, ea[g]});
        chk(g, "done_cs", cs[g], 1);
        dones[g]++;
      end
      if (!cs[g]) begin
        if (mosi[g] != pmosi[g]) chk(g, "mosi_low", sclk[g], 0);
        if (sclk[g] && !psclk[g]) begin
          chk(g, "mosi_setup", stab[g] >= cd[g], 1);
          if (first_rise[g]) chk(g, "first_edge", since_cs[g], cd[g]);
          first_rise[g] = 1'b0;
        end
        if (rise[g] >= 16 && !sclk[g]) chk(g, "read_mosi", mosi[g], 0);
      end
    end
    stab[g] = (mosi[g] == pmosi[g]) ? stab[g] + 1 : 1;
    since_cs[g] = cs[g] ? 0 : since_cs[g] + 1;
    if (cs[g]) first_rise[g] = 1'b1;
    pv[g] = bvalid[g];
    pdat[g] = bdata[g];
    psclk[g] = sclk[g];
    pmosi[g] = mosi[g];
    pdone[g] = done[g];
  endtask

  task automatic tick();
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      eeprom(g);
      compare(g);
    end
  endtask

  task automatic go(input int g, input logic [7:0] a);
    tick();
    start_addr[g] = a;
    start[g] = 1'b1;
    tick();
    start[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, input int budget, input bit toggle);
    int n;
    n = 0;
    while (!done[g] && n < budget) begin
      if (toggle) byte_ready[g] = ~byte_ready[g];
      tick();
      n++;
    end
    chk(g, "done_wait", done[g], 1);
  endtask

  initial begin
    int n, d0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 11);
    mem[8'h10] = 8'hA5;
    mem[8'h11] = 8'h3C;
    mem[8'h12] = 8'h00;
    mem[8'h13] = 8'hFF;
    bc[0] = 4;
    bc[1] = 256;
    cd[0] = 2;
    cd[1] = 1;
    for (int g = 0; g < 2; g++) begin
      start_addr[g] = 8'h00;
      psclk[g] = 1'b0;
      pmosi[g] = 1'b0;
      pdone[g] = 1'b0;
      pv[g] = 1'b0;
      cmd[g] = '0;
    end
    reset = 2'b11;
    start = 2'b00;
    byte_ready = 2'b00;
    miso = 2'b00;
`ifdef EEPROM_STREAM_ABORT_EN
    abort = 2'b00;
`endif
    tick();
    tick();
    reset = 2'b00;
    tick();
    byte_ready[0] = 1'b1;
    go(0, 8'h10);
    wait_done(0, 1000, 1'b0);
    chk(0, "a_len", got0.size(), 4);
    for (int i = 0; i < 4; i++) chk(0, "a_stream", got0[i], lit[i]);
    chk(0, "a_cmd", cmd[0], 16'h0310);
    chk(0, "a_dones", dones[0], 1);
    tick();
    chk(0, "a_cs_after", cs[0], 1);
    chk(0, "a_busy_after", busy[0], 0);
    got0.delete();
    d0 = dones[0];
    byte_ready[0] = 1'b0;
    go(0, 8'h20);
    n = 0;
    while (!bvalid[0] && n < 500) begin
      tick();
      n++;
    end
    chk(0, "valid_wait", bvalid[0], 1);
    start_addr[0] = 8'h99;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    repeat (19) tick();
    chk(0, "b_stall_xfer", xfer[0], 0);
    chk(0, "b_stall_valid", bvalid[0], 1);
    chk(0, "b_stall_data", bdata[0], 8'hAB);
    wait_done(0, 2000, 1'b1);
    chk(0, "b_dones", dones[0], d0 + 1);
    chk(0, "b_len", got0.size(), 4);
    byte_ready[0] = 1'b1;
    go(0, 8'h40);
    n = 0;
    while (rise[0] < 37 && n < 2000) begin
      tick();
      n++;
    end
    chk(0, "rise_wait", rise[0] >= 37, 1);
    d0 = dones[0];
    reset[0] = 1'b1;
    tick();
    reset[0] = 1'b0;
    got0.delete();
    go(0, 8'h10);
    wait_done(0, 1000, 1'b0);
    chk(0, "c_dones", dones[0], d0 + 1);
    chk(0, "c_len", got0.size(), 4);
    for (int i = 0; i < 4; i++) chk(0, "c_stream", got0[i], lit[i]);
    byte_ready[1] = 1'b1;
    go(1, 8'hF0);
    wait_done(1, 20000, 1'b0);
    chk(1, "d_xfer", xfer[1], 256);
    tick();
    chk(1, "d_dones", dones[1], 1);
    chk(1, "d_cs_after", cs[1], 1);
`ifdef EEPROM_STREAM_ABORT_EN
    d0 = dones[0];
    go(0, 8'h55);
    n = 0;
    while (rise[0] < 10 && n < 500) begin
      tick();
      n++;
    end
    chk(0, "addr_wait", rise[0] >= 10, 1);
    abort[0] = 1'b1;
    tick();
    abort[0] = 1'b0;
    chk(0, "ab_cs", cs[0], 1);
    chk(0, "ab_busy", busy[0], 0);
    chk(0, "ab_sclk", sclk[0], 0);
    chk(0, "ab_valid", bvalid[0], 0);
    repeat (40) tick();
    chk(0, "ab_no_done", dones[0], d0);
    chk(0, "ab_no_byte", xfer[0], 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/eeprom_stream_reader.md
EEPROM_STREAM_READER -- requirements
Module: eeprom_stream_reader

Interface
REQ-001 SHALL have parameter BYTE_COUNT, default 100, meaning data bytes read per transaction (legal 1..256).
REQ-002 SHALL have parameter CLK_DIV, default 2, meaning clk cycles per SCLK half-period (legal >=1).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a read transaction.
REQ-006 SHALL have port start_addr  input  8  EEPROM start address, sampled on accepted start.
REQ-007 SHALL have port busy  output  1  high from accepted start until done.
REQ-008 SHALL have port done  output  1  one-cycle pulse at transaction end.
REQ-009 SHALL have ports eeprom_cs (output, 1, active-low), eeprom_clk (output, 1, SPI SCLK), eeprom_in (output, 1, MOSI), eeprom_out (input, 1, MISO).
REQ-010 SHALL have ports byte_data (output, 8), byte_valid (output, 1) and byte_ready (input, 1), forming the downstream valid/ready stream into the pattern shift register.

Function
REQ-011 SHALL implement states IDLE, CMD, ADDR, READ, HOLD, DONE.
REQ-012 IDLE: eeprom_cs=1, eeprom_clk=0; start=1 -> CMD next cycle, cs low that same cycle, start_addr latched; start while busy SHALL be ignored.
REQ-013 CMD shifts opcode 8'h03, ADDR shifts latched address; both MSB first, SPI mode 0.
REQ-014 MOSI SHALL change only while eeprom_clk is low and SHALL be stable >= CLK_DIV cycles before each rising edge.
REQ-015 Each bit SHALL be CLK_DIV cycles low then CLK_DIV cycles high; first rising edge CLK_DIV cycles after cs falls.
REQ-016 READ samples eeprom_out on the cycle eeprom_clk rises; MOSI held 0.
REQ-017 Byte completes when the 8th high half-period ends; eeprom_clk returns low, and one cycle later byte_valid=1 with byte_data = assembled byte.
REQ-018 byte_data SHALL stay stable and byte_valid high until a cycle with byte_valid && byte_ready; the transfer takes place in that cycle.
REQ-019 While a byte is unaccepted, state SHALL be HOLD: eeprom_clk low, cs low, no clocking (stall).
REQ-020 On acceptance: if bytes transferred < BYTE_COUNT -> READ, next byte starts the following cycle; else -> DONE.
REQ-021 DONE: eeprom_cs=1, done=1 for exactly one cycle, busy=0 the cycle after, -> IDLE.
REQ-022 Byte counter SHALL be 9 bits; BYTE_COUNT=256 SHALL transfer exactly 256 bytes; address wrap is the EEPROM's concern.
REQ-023 byte_ready asserted with byte_valid low SHALL have no effect.

Reset
REQ-024 Reset SHALL, at the next clk edge from any state, force IDLE, eeprom_cs=1, eeprom_clk=0, eeprom_in=0, byte_valid=0, busy=0, done=0, byte_data=8'h00, counters=0.
REQ-025 A pending unaccepted byte SHALL be discarded by reset.

Configuration
REQ-026 With EEPROM_STREAM_ABORT_EN defined, SHALL add input abort (1 bit): abort=1 in any non-IDLE state -> next cycle IDLE, cs=1, clk=0, byte_valid=0, no done pulse.
REQ-027 Without EEPROM_STREAM_ABORT_EN, port abort SHALL not exist and transactions always complete.

Structure
REQ-028 Shared package eeprom_pkg SHALL hold the READ opcode constant (8'h03) and the state enumeration.
REQ-029 A sub-module spi_byte_shifter (8-bit MSB-first shift, SCLK divider, bit counter, byte-complete pulse) SHALL be used for CMD, ADDR and READ.

Verification
REQ-030 CLK_DIV=2, BYTE_COUNT=4, start_addr=8'h10, byte_ready=1, EEPROM model returns A5,3C,00,FF -> MOSI 0x03,0x10; stream A5,3C,00,FF; one done; cs high afterwards.
REQ-031 byte_ready held 0 for 20 cycles after first byte -> byte_valid/byte_data stable, eeprom_clk low with no edges for 20 cycles, then resume.
REQ-032 Reset asserted mid-READ (byte 2, bit 5) -> next edge cs=1, clk=0, valid=0, busy=0; subsequent start reads normally from byte 0.
REQ-033 start pulsed again during busy -> ignored; exactly BYTE_COUNT bytes, one done.
REQ-034 BYTE_COUNT=256, CLK_DIV=1 -> exactly 256 valid transfers, counter no overflow, done once.
REQ-035 With EEPROM_STREAM_ABORT_EN, abort during ADDR -> cs high next cycle, no done, no byte_valid.
